// File: rtl/arf_ctrl_pkg.sv
// Shared encodings for the address register file controls: FunSel codes,
// one-cold RegSel masks, OutC/OutD select codes, request opcodes, and the
// bundle of per-cycle control outputs.
package arf_ctrl_pkg;

  // FunSel: operation applied to every register whose RegSel bit is low
  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;

  // RegSel: active-low enables ordered {PC, AR, SP}
  localparam logic [2:0] RS_PC   = 3'b011;
  localparam logic [2:0] RS_AR   = 3'b101;
  localparam logic [2:0] RS_SP   = 3'b110;
  localparam logic [2:0] RS_NONE = 3'b111;
  localparam logic [2:0] RS_ALL  = 3'b000;

  // OutCSel / OutDSel source codes
  localparam logic [1:0] SEL_PC = 2'b00;
  localparam logic [1:0] SEL_AR = 2'b10;
  localparam logic [1:0] SEL_SP = 2'b11;

  // Request opcodes; anything else is illegal and gets rejected
  localparam logic [2:0] OP_FETCH   = 3'b000;
  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_JUMP    = 3'b011;
  localparam logic [2:0] OP_LOAD_AR = 3'b100;

  // All per-cycle control outputs, registered together
  typedef struct packed {
    logic [2:0] fun_sel;
    logic [2:0] reg_sel;
    logic [1:0] outc_sel;
    logic [1:0] outd_sel;
    logic       mem_read;
    logic       mem_write;
    logic       byte_sel;
    logic       done;
    logic       error;
  } ctrl_t;

  // Quiet value: no register enabled, no strobes
  localparam ctrl_t CTRL_IDLE = '{
    fun_sel:   FS_DEC,
    reg_sel:   RS_NONE,
    outc_sel:  SEL_PC,
    outd_sel:  SEL_PC,
    mem_read:  1'b0,
    mem_write: 1'b0,
    byte_sel:  1'b0,
    done:      1'b0,
    error:     1'b0
  };

endpackage

// File: rtl/arf_op_sequencer_if.sv
// Request handshake plus ARF/memory control bundle for the address op sequencer.
// Handshake: a request transfers on a rising edge where ReqValid and ReqReady are
// both high; ReqReady depends on sequencer state only, and the requester must hold
// ReqOp stable while ReqValid is high and ReqReady is low.
interface arf_op_sequencer_if #(
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic          ReqValid;
  logic [2:0]    ReqOp;
  logic          ReqReady;
  logic [2:0]    FunSel;
  logic [2:0]    RegSel;
  logic [1:0]    OutCSel;
  logic [1:0]    OutDSel;
  logic          MemRead;
  logic          MemWrite;
  logic          ByteSel;
  logic          Done;
  logic          Error;
  logic [DW-1:0] Depth;
  logic [3:0]    DbgState;

  // Sequencer side
  modport slave (
    input  ReqValid, ReqOp,
    output ReqReady, FunSel, RegSel, OutCSel, OutDSel,
           MemRead, MemWrite, ByteSel, Done, Error, Depth, DbgState
  );

  // Decoder side
  modport master (
    output ReqValid, ReqOp,
    input  ReqReady, FunSel, RegSel, OutCSel, OutDSel,
           MemRead, MemWrite, ByteSel, Done, Error, Depth, DbgState
  );

endinterface

// File: rtl/arf_op_sequencer.sv
// Address register file sequencer: accepts one PC/AR/SP operation at a time and
// plays out its per-cycle ARF controls and memory strobes. All outputs except
// ReqReady are registered alongside the state, so the request inputs never reach
// them combinationally. Stack depth is tracked so over/underflow is rejected
// instead of corrupting SP.
module arf_op_sequencer
  import arf_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  arf_op_sequencer_if.slave bus
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_IDLE     = 4'd1,
    ST_FETCH_LO = 4'd2,
    ST_FETCH_HI = 4'd3,
    ST_PUSH_DEC = 4'd4,
    ST_PUSH_WR  = 4'd5,
    ST_POP_RD   = 4'd6,
    ST_POP_INC  = 4'd7,
    ST_LOAD_PC  = 4'd8,
    ST_LOAD_AR  = 4'd9,
    ST_REJECT   = 4'd10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  ctrl_t         r_ctrl;
  ctrl_t         w_ctrl;
  logic [DW-1:0] r_depth;

  // Control outputs owned by each state
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      ST_INIT: begin
        c.fun_sel = FS_CLR;
        c.reg_sel = RS_ALL;
      end
      ST_FETCH_LO, ST_FETCH_HI: begin
        c.fun_sel  = FS_INC;
        c.reg_sel  = RS_PC;
        c.outd_sel = SEL_PC;
        c.mem_read = 1'b1;
        c.byte_sel = (s == ST_FETCH_HI);
        c.done     = (s == ST_FETCH_HI);
      end
      ST_PUSH_DEC: begin
        c.fun_sel = FS_DEC;
        c.reg_sel = RS_SP;
      end
      ST_PUSH_WR: begin
        c.outd_sel  = SEL_SP;
        c.mem_write = 1'b1;
        c.done      = 1'b1;
      end
      ST_POP_RD: begin
        c.outd_sel = SEL_SP;
        c.mem_read = 1'b1;
      end
      ST_POP_INC: begin
        c.fun_sel = FS_INC;
        c.reg_sel = RS_SP;
        c.done    = 1'b1;
      end
      ST_LOAD_PC: begin
        c.fun_sel = FS_LOAD;
        c.reg_sel = RS_PC;
        c.done    = 1'b1;
      end
      ST_LOAD_AR: begin
        c.fun_sel  = FS_LOAD;
        c.reg_sel  = RS_AR;
        c.outc_sel = SEL_AR;
        c.done     = 1'b1;
      end
      ST_REJECT: c.error = 1'b1;
      default:   c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Next-state selection; stack bounds are judged at acceptance time
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: w_next = ST_IDLE;
      ST_IDLE: begin
        if (bus.ReqValid) begin
          case (bus.ReqOp)
            OP_FETCH:   w_next = ST_FETCH_LO;
            OP_PUSH:    w_next = (r_depth < DEPTH_MAX) ? ST_PUSH_DEC : ST_REJECT;
            OP_POP:     w_next = (r_depth != '0) ? ST_POP_RD : ST_REJECT;
            OP_JUMP:    w_next = ST_LOAD_PC;
            OP_LOAD_AR: w_next = ST_LOAD_AR;
            default:    w_next = ST_REJECT;
          endcase
        end
      end
      ST_FETCH_LO: w_next = ST_FETCH_HI;
      ST_PUSH_DEC: w_next = ST_PUSH_WR;
      ST_POP_RD:   w_next = ST_POP_INC;
      ST_FETCH_HI, ST_PUSH_WR, ST_POP_INC,
      ST_LOAD_PC, ST_LOAD_AR, ST_REJECT: w_next = ST_IDLE;
      default:     w_next = ST_INIT;
    endcase
  end

  // Outputs are decoded from the state being entered so they appear with it
  always_comb begin
    w_ctrl = decode(w_next);
  end

  // State, registered outputs and stack depth; reset lands in INIT to clear the ARF
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_INIT;
      r_ctrl  <= decode(ST_INIT);
      r_depth <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl;
      if (r_state == ST_PUSH_WR) begin
        r_depth <= r_depth + DW'(1);
      end else if (r_state == ST_POP_INC) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  assign bus.ReqReady = (r_state == ST_IDLE);
  assign bus.FunSel   = r_ctrl.fun_sel;
  assign bus.RegSel   = r_ctrl.reg_sel;
  assign bus.OutCSel  = r_ctrl.outc_sel;
  assign bus.OutDSel  = r_ctrl.outd_sel;
  assign bus.MemRead  = r_ctrl.mem_read;
  assign bus.MemWrite = r_ctrl.mem_write;
  assign bus.ByteSel  = r_ctrl.byte_sel;
  assign bus.Done     = r_ctrl.done;
  assign bus.Error    = r_ctrl.error;
  assign bus.Depth    = r_depth;
  assign bus.DbgState = r_state;

endmodule
